// File: rtl/cpu_pkg.sv
// Shared widths, the hard-wired zero register and the writeback source tag.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PRI,
    SRC_SEC
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering secondary writeback requests.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_c  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: primary writeback, buffered secondary
// producer, pending-write scoreboard and anti-starvation hold.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W       = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W       = cpu_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_hold,
  input  logic              s_valid,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_stall,
  input  logic [ADDR_W-1:0] regaAddr,
  input  logic [ADDR_W-1:0] regbAddr,
  input  logic              regaRd,
  input  logic              regbRd,
  output logic              rd_stall,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData
);

  import cpu_pkg::*;

  localparam int unsigned NREG   = 2**ADDR_W;
  localparam int unsigned ENT_W  = ADDR_W + DATA_W;
  localparam int unsigned OCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic [NREG-1:0]   pending;
  logic [OCNT_W-1:0] outstanding;
  logic [SCNT_W-1:0] starve_cnt;
  src_e              src_q;

  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  src_e              src_d;
  logic              sb_set;
  logic              sb_clr;
  logic              starve_inc;
  logic              hold_d;

  assign head_addr = fifo_head[DATA_W +: ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];
  assign s_ready   = !fifo_full;
  assign push      = s_valid && s_ready;
  assign pop       = !p_we && !fifo_empty;

  wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wdata   ({s_addr, s_data}),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .head_c  (fifo_head)
  );

  assign iss_stall = iss_valid &&
                     (pending[iss_addr] || (outstanding >= OCNT_W'(FIFO_DEPTH)));
  assign rd_stall  = (regaRd && pending[regaAddr]) || (regbRd && pending[regbAddr]);

  // Arbitration, scoreboard update and starvation detection.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = wAddr;
    wdata_d = wData;
    src_d   = SRC_NONE;
    if (p_we) begin
      waddr_d = p_addr;
      wdata_d = p_data;
      if (p_addr != ADDR_W'(ZERO_REG)) begin
        we_d  = 1'b1;
        src_d = SRC_PRI;
      end
    end else if (!fifo_empty) begin
      waddr_d = head_addr;
      wdata_d = head_data;
      if (head_addr != ADDR_W'(ZERO_REG)) begin
        we_d  = 1'b1;
        src_d = SRC_SEC;
      end
    end
    sb_set     = iss_valid && !iss_stall && (iss_addr != ADDR_W'(ZERO_REG));
    // Clear lands on the edge the register file captures the secondary data.
    sb_clr     = we && (src_q == SRC_SEC) && pending[wAddr];
    starve_inc = !fifo_empty && p_we;
    hold_d     = starve_inc && (starve_cnt >= SCNT_W'(STARVE_LIMIT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we     <= 1'b0;
      wAddr  <= '0;
      wData  <= '0;
      src_q  <= SRC_NONE;
      p_hold <= 1'b0;
    end else begin
      we     <= we_d;
      wAddr  <= waddr_d;
      wData  <= wdata_d;
      src_q  <= src_d;
      p_hold <= hold_d;
    end
  end

  // Set and clear never target the same bit: set requires the bit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      if (sb_clr) pending[wAddr]    <= 1'b0;
      if (sb_set) pending[iss_addr] <= 1'b1;
      outstanding <= outstanding + OCNT_W'(sb_set) - OCNT_W'(sb_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SCNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SCNT_W'(1);
    end
  end

  a_no_waw: assert property (@(posedge clk) disable iff (rst)
    !(p_we && (p_addr != ADDR_W'(ZERO_REG)) && pending[p_addr]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_we, s_valid, iss_valid, regaRd, regbRd;
  logic [AW-1:0] p_addr, s_addr, iss_addr, regaAddr, regbAddr;
  logic [DW-1:0] p_data, s_data;
  logic          p_hold, s_ready, iss_stall, rd_stall, we;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_hold(p_hold),
    .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data), .s_ready(s_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .regaAddr(regaAddr), .regbAddr(regbAddr), .regaRd(regaRd), .regbRd(regbRd),
    .rd_stall(rd_stall), .we(we), .wAddr(wAddr), .wData(wData)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending set, FIFO contents, what the port shows now.
  bit            m_pend [32];
  logic [AW-1:0] mq_a [$];
  logic [DW-1:0] mq_d [$];
  bit            m_we, m_sec, m_hold;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_lost;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    mq_a.delete();
    mq_d.delete();
    m_we = 0; m_sec = 0; m_hold = 0; m_waddr = '0; m_wdata = '0; m_lost = 0;
  endtask

  task automatic idle_inputs();
    p_we = 0; p_addr = '0; p_data = '0;
    s_valid = 0; s_addr = '0; s_data = '0;
    iss_valid = 0; iss_addr = '0;
    regaRd = 0; regbRd = 0; regaAddr = '0; regbAddr = '0;
  endtask

  task automatic compare();
    bit exp_rd, exp_iss;
    exp_rd  = (regaRd && m_pend[regaAddr]) || (regbRd && m_pend[regbAddr]);
    exp_iss = iss_valid && (m_pend[iss_addr] || pend_count() >= DEPTH);
    chk("we", 32'(we), 32'(m_we));
    chk("p_hold", 32'(p_hold), 32'(m_hold));
    chk("s_ready", 32'(s_ready), 32'(mq_a.size() < DEPTH));
    chk("rd_stall", 32'(rd_stall), 32'(exp_rd));
    chk("iss_stall", 32'(iss_stall), 32'(exp_iss));
    if (m_we) begin
      chk("wAddr", 32'(wAddr), 32'(m_waddr));
      chk("wData", wData, m_wdata);
    end
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_edge();
    int  size = mq_a.size();
    bit  sec  = !p_we && size > 0;
    bit  iss_ok;
    bit  n_we = 0, n_sec = 0, n_hold;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    iss_ok = iss_valid && !(m_pend[iss_addr] || pend_count() >= DEPTH) && iss_addr != 0;
    n_hold = (size > 0) && p_we && (m_lost >= LIMIT - 1);
    if (sec || size == 0) m_lost = 0;
    else if (m_lost < LIMIT) m_lost++;
    if (m_we && m_sec) m_pend[m_waddr] = 1'b0;
    if (iss_ok) m_pend[iss_addr] = 1'b1;
    if (p_we) begin
      n_we = (p_addr != 0); a = p_addr; d = p_data;
    end else if (sec) begin
      a = mq_a.pop_front(); d = mq_d.pop_front();
      n_we = (a != 0); n_sec = n_we;
    end
    if (s_valid && size < DEPTH) begin
      mq_a.push_back(s_addr); mq_d.push_back(s_data);
    end
    if (n_we) begin m_waddr = a; m_wdata = d; end
    m_we = n_we; m_sec = n_sec; m_hold = n_hold;
  endtask

  task automatic tick();
    #1;
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_rd_stall", 32'(rd_stall), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_wAddr", 32'(wAddr), 32'd0);
    chk("reset_wData", wData, 32'd0);
    chk("reset_p_hold", 32'(p_hold), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Primary write has one-cycle latency.
    p_we = 1; p_addr = 5; p_data = 32'hDEADBEEF;
    tick();
    chk("pri_we", 32'(we), 32'd1);
    chk("pri_wAddr", 32'(wAddr), 32'd5);
    chk("pri_wData", wData, 32'hDEADBEEF);
    p_we = 0;
    tick();
    chk("pri_we_off", 32'(we), 32'd0);

    // Long-latency round trip on r8.
    iss_valid = 1; iss_addr = 8;
    tick();
    iss_valid = 0; regaRd = 1; regaAddr = 8;
    #1 chk("rt_rd_stall_set", 32'(rd_stall), 32'd1);
    s_valid = 1; s_addr = 8; s_data = 32'h1234;
    tick();
    s_valid = 0;
    tick();
    chk("rt_we", 32'(we), 32'd1);
    chk("rt_wAddr", 32'(wAddr), 32'd8);
    chk("rt_wData", wData, 32'h1234);
    chk("rt_rd_stall_hold", 32'(rd_stall), 32'd1);
    tick();
    chk("rt_rd_stall_clr", 32'(rd_stall), 32'd0);
    regaRd = 0;

    // Contention: primary busy every cycle, r9 waits for the hold.
    p_we = 1; p_addr = 20; p_data = 32'h100;
    s_valid = 1; s_addr = 9; s_data = 32'h99;
    tick();
    s_valid = 0;
    for (int i = 1; i <= LIMIT; i++) begin
      p_data = 32'h100 + 32'(i);
      tick();
      if (i == LIMIT - 1) chk("starve_hold_early", 32'(p_hold), 32'd0);
    end
    chk("starve_hold", 32'(p_hold), 32'd1);
    p_we = 0;
    tick();
    chk("starve_we", 32'(we), 32'd1);
    chk("starve_wAddr", 32'(wAddr), 32'd9);
    chk("starve_wData", wData, 32'h99);
    chk("starve_hold_off", 32'(p_hold), 32'd0);

    // Backpressure: two entries fill the buffer.
    p_we = 1; p_addr = 21;
    s_valid = 1; s_addr = 10; s_data = 32'hA;
    tick();
    s_addr = 11; s_data = 32'hB;
    tick();
    chk("bp_full", 32'(s_ready), 32'd0);
    s_addr = 13; s_data = 32'hC;
    tick();
    chk("bp_still_full", 32'(s_ready), 32'd0);
    p_we = 0;
    tick();
    chk("bp_pop1", 32'(wAddr), 32'd10);
    chk("bp_ready", 32'(s_ready), 32'd1);
    tick();
    chk("bp_pop2", 32'(wAddr), 32'd11);
    s_valid = 0;
    tick();
    chk("bp_pop3", 32'(wAddr), 32'd13);
    chk("bp_pop3_data", wData, 32'hC);
    tick();
    chk("bp_idle", 32'(we), 32'd0);

    // Issue limits and r0 handling.
    iss_valid = 1; iss_addr = 3;
    tick();
    #1 chk("iss_dup_stall", 32'(iss_stall), 32'd1);
    tick();
    iss_addr = 0;
    #1 chk("iss_r0_ok", 32'(iss_stall), 32'd0);
    tick();
    iss_addr = 4;
    #1 chk("iss_r4_ok", 32'(iss_stall), 32'd0);
    tick();
    iss_addr = 5;
    #1 chk("iss_slots_full", 32'(iss_stall), 32'd1);
    iss_valid = 0;
    s_valid = 1; s_addr = 0; s_data = 32'h77;
    tick();
    s_valid = 0;
    tick();
    chk("r0_dropped", 32'(we), 32'd0);
    s_valid = 1; s_addr = 3; s_data = 32'h33;
    tick();
    s_addr = 4; s_data = 32'h44;
    tick();
    s_valid = 0;
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      int np;
      p_we = m_hold ? 1'b0 : ($urandom_range(0, 1) == 1);
      p_addr = AW'($urandom_range(0, 31));
      if (m_pend[p_addr]) p_addr = '0;
      p_data = $urandom();
      s_valid = ($urandom_range(0, 9) < 4);
      s_addr = AW'($urandom_range(0, 31));
      np = pend_count();
      if (np > 0 && $urandom_range(0, 1) == 1) begin
        for (int r = 0; r < 32; r++) if (m_pend[r]) s_addr = AW'(r);
      end
      s_data = $urandom();
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_addr = AW'($urandom_range(0, 31));
      regaRd = $urandom_range(0, 1) == 1;
      regbRd = $urandom_range(0, 1) == 1;
      regaAddr = AW'($urandom_range(0, 31));
      regbAddr = AW'($urandom_range(0, 31));
      tick();
    end

    // Clean up random state, then reset with r12 in flight.
    idle_inputs();
    pulse_reset();
    iss_valid = 1; iss_addr = 12;
    p_we = 1; p_addr = 20; p_data = 32'h2020;
    tick();
    iss_valid = 0;
    s_valid = 1; s_addr = 12; s_data = 32'h55;
    p_addr = 21; p_data = 32'h2121;
    tick();
    idle_inputs();
    regaRd = 1; regaAddr = 12;
    #1 chk("mid_rd_stall", 32'(rd_stall), 32'd1);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_write", 32'(we), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
